// File: rtl/mod47_frame_acc.sv
// Frame accumulator: sums mod-47 residue terms per frame and holds the result
// until downstream takes it. Out-of-range inputs (47..63) are folded and flagged.
module mod47_frame_acc #(
    parameter int N_TERMS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [5:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [5:0] out_data,
    output logic       out_err,
    input  logic       out_ready
);

    localparam int CW = $clog2(N_TERMS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_TERMS - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      acc_q, acc_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic            term_bad;
    logic            frame_end;
    logic [5:0]      term_r;
    logic [6:0]      sum;
    logic [5:0]      sum_mod;

    // Handshakes: a transfer happens only on a cycle where valid and ready are
    // both high at the rising edge; ready never depends on valid.
    assign accept    = in_valid && (state_q == ACC);
    assign term_bad  = (in_data >= 6'd47);
    assign term_r    = term_bad ? (in_data - 6'd47) : in_data;
    assign sum       = {1'b0, acc_q} + {1'b0, term_r};
    assign sum_mod   = (sum >= 7'd47) ? 6'(sum - 7'd47) : sum[5:0];
    assign frame_end = in_last || (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= 6'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = sum_mod;
                    err_d = err_q | term_bad;
                    cnt_d = cnt_q + CW'(1);
                    if (frame_end) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Result leaves and the next frame starts clean on the same edge.
                if (out_ready) begin
                    state_d = ACC;
                    acc_d   = 6'd0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_mod47_frame_acc.sv
// Directed bench for mod47_frame_acc: an N_TERMS=4 instance for the main frame
// cases and an N_TERMS=1 instance for single-term frames.
module tb_mod47_frame_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       v4 = 1'b0, l4 = 1'b0, ordy4 = 1'b0;
    logic [5:0] d4 = 6'd0;
    logic       irdy4, ov4, oe4;
    logic [5:0] od4;

    logic       v1 = 1'b0, l1 = 1'b0, ordy1 = 1'b0;
    logic [5:0] d1 = 6'd0;
    logic       irdy1, ov1, oe1;
    logic [5:0] od1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod47_frame_acc #(.N_TERMS(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_data(d4), .in_last(l4), .in_ready(irdy4),
        .out_valid(ov4), .out_data(od4), .out_err(oe4), .out_ready(ordy4)
    );

    mod47_frame_acc #(.N_TERMS(1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(v1), .in_data(d1), .in_last(l1), .in_ready(irdy1),
        .out_valid(ov1), .out_data(od1), .out_err(oe1), .out_ready(ordy1)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the term was accepted.
    task automatic send4(input logic [5:0] d, input logic last);
        int n;
        v4 = 1'b1; d4 = d; l4 = last;
        n = 0;
        while (!irdy4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!irdy4) check_eq("send4_timeout", 8'd0, 8'd1);
        @(negedge clk);
        v4 = 1'b0; l4 = 1'b0;
    endtask

    // Called right after the frame-ending accept; checks latency-1 result and drains it.
    task automatic take4(input string tag, input logic [5:0] exp_d, input logic exp_e);
        check_eq({tag, "_valid"}, {7'd0, ov4}, 8'd1);
        check_eq({tag, "_data"},  {2'd0, od4}, {2'd0, exp_d});
        check_eq({tag, "_err"},   {7'd0, oe4}, {7'd0, exp_e});
        ordy4 = 1'b1;
        @(negedge clk);
        ordy4 = 1'b0;
        check_eq({tag, "_drained"}, {7'd0, ov4}, 8'd0);
        check_eq({tag, "_ready"},   {7'd0, irdy4}, 8'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready",  {7'd0, irdy4}, 8'd1);
        check_eq("rst_out_valid", {7'd0, ov4},   8'd0);
        check_eq("rst_out_data",  {2'd0, od4},   8'd0);
        check_eq("rst_out_err",   {7'd0, oe4},   8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Four maximal terms, frame ended by the term counter.
        send4(6'd46, 1'b0); send4(6'd46, 1'b0); send4(6'd46, 1'b0);
        check_eq("cnt_no_early_end", {7'd0, ov4}, 8'd0);
        send4(6'd46, 1'b0);
        take4("f46x4", 6'd43, 1'b0);

        // in_last ends a short frame.
        send4(6'd10, 1'b0); send4(6'd40, 1'b1);
        take4("last_10_40", 6'd3, 1'b0);

        // Out-of-range term folds to 3 and flags the frame; acc restarted at 0.
        send4(6'd50, 1'b0); send4(6'd0, 1'b0); send4(6'd0, 1'b0); send4(6'd0, 1'b0);
        take4("err_50", 6'd3, 1'b1);

        // Backpressure: result stays put, input pulses are ignored.
        send4(6'd1, 1'b0); send4(6'd2, 1'b0); send4(6'd3, 1'b0); send4(6'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            v4 = i[0]; d4 = 6'd9; l4 = 1'b1;
            check_eq("hold_valid",    {7'd0, ov4},   8'd1);
            check_eq("hold_data",     {2'd0, od4},   8'd10);
            check_eq("hold_err",      {7'd0, oe4},   8'd0);
            check_eq("hold_in_ready", {7'd0, irdy4}, 8'd0);
            @(negedge clk);
        end
        v4 = 1'b0; l4 = 1'b0;
        take4("hold_deliver", 6'd10, 1'b0);

        // Asynchronous reset mid-frame discards the partial sum.
        send4(6'd20, 1'b0); send4(6'd30, 1'b0);
        check_eq("pre_rst_data", {2'd0, od4}, 8'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_in_ready",  {7'd0, irdy4}, 8'd1);
        check_eq("async_rst_out_valid", {7'd0, ov4},   8'd0);
        check_eq("async_rst_out_data",  {2'd0, od4},   8'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        send4(6'd5, 1'b0); send4(6'd5, 1'b0); send4(6'd5, 1'b0); send4(6'd5, 1'b0);
        take4("after_rst", 6'd20, 1'b0);

        // N_TERMS=1: every term is its own frame, one accept every two cycles.
        v1 = 1'b1; d1 = 6'd7; ordy1 = 1'b1;
        check_eq("n1_ready0", {7'd0, irdy1}, 8'd1);
        @(negedge clk);
        check_eq("n1_valid0", {7'd0, ov1},   8'd1);
        check_eq("n1_data0",  {2'd0, od1},   8'd7);
        check_eq("n1_err0",   {7'd0, oe1},   8'd0);
        check_eq("n1_busy0",  {7'd0, irdy1}, 8'd0);
        d1 = 6'd47;
        @(negedge clk);
        check_eq("n1_gap",    {7'd0, ov1},   8'd0);
        check_eq("n1_ready1", {7'd0, irdy1}, 8'd1);
        @(negedge clk);
        check_eq("n1_valid1", {7'd0, ov1},   8'd1);
        check_eq("n1_data1",  {2'd0, od1},   8'd0);
        check_eq("n1_err1",   {7'd0, oe1},   8'd1);
        v1 = 1'b0;
        @(negedge clk);
        check_eq("n1_drained", {7'd0, ov1}, 8'd0);
        ordy1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mod47_frame_acc.md
MOD47_FRAME_ACC -- requirements
Module: mod47_frame_acc

Interface
REQ-001 SHALL have parameter N_TERMS, default 8, maximum terms per frame; legal range 1..256.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream residue word valid.
REQ-005 SHALL have port in_data  input  6  residue word from the upstream 6-in/6-out mod-47 LUT stage; nominal range 0..46.
REQ-006 SHALL have port in_last  input  1  marks the final term of the current frame; qualified by in_valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a term this cycle.
REQ-008 SHALL have port out_valid  output  1  frame result valid.
REQ-009 SHALL have port out_data  output  6  frame sum mod 47, range 0..46.
REQ-010 SHALL have port out_err  output  1  at least one term in the frame was out of range (47..63).
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-012 SHALL implement a two-state FSM: ACC and HOLD.
REQ-013 SHALL drive in_ready=1 only in ACC and out_valid=1 only in HOLD.
REQ-014 SHALL accept a term when in_valid and in_ready are both 1 in the same cycle; no term is consumed otherwise.
REQ-015 SHALL normalise each accepted term: r = in_data if in_data<47, else in_data-47 (47..63 maps to 0..16).
REQ-016 SHALL update acc <= (acc + r) mod 47 on accept, using a 7-bit sum and one conditional subtract of 47; acc never leaves 0..46.
REQ-017 SHALL set the frame error flag on accept of any in_data>=47; the flag is sticky for the rest of the frame.
REQ-018 SHALL keep a term counter, width clog2(N_TERMS+1), incremented on each accept.
REQ-019 SHALL end the frame on the accept where in_last=1 or the counter reaches N_TERMS, whichever comes first.
REQ-020 SHALL fold the final term into the result, so out_data includes it.
REQ-021 SHALL transition ACC->HOLD on the frame-ending accept.
REQ-022 SHALL present out_valid the cycle after that accept (latency 1), with out_data = final acc and out_err = frame error flag.
REQ-023 SHALL hold out_data and out_err stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on out_valid and out_ready both 1, transition HOLD->ACC and clear acc, counter and error flag in the same edge; in_ready=1 from the next cycle.
REQ-025 SHALL NOT accept input in the same cycle as the output handshake, since in_ready=0 in HOLD.
REQ-026 SHALL ignore in_last when in_valid=0, and ignore in_data and in_last in HOLD.
REQ-027 SHALL NOT let the counter wrap; the frame always ends at N_TERMS.
REQ-028 SHALL, with N_TERMS=1, emit every accepted term as its own frame.
REQ-029 SHALL make every output registered or a pure decode of the state register, with no combinational path from in_* to out_*.

Reset
REQ-030 SHALL, on rst=1 at any time and independent of clk, force state=ACC, acc=0, counter=0 and error flag=0.
REQ-031 SHALL hold outputs during reset at in_ready=1, out_valid=0, out_data=0, out_err=0.
REQ-032 SHALL discard any partial frame or undelivered result on reset mid-operation; the first frame after reset deassertion starts from acc=0.

Verification
REQ-033 SHALL be verified with N_TERMS=4, terms 46,46,46,46 and no in_last -> out_valid one cycle after 4th accept, out_data=43, out_err=0.
REQ-034 SHALL be verified with terms 10,40 and in_last on 40 -> out_data=3 after 2 terms, out_err=0; next frame starts at acc=0.
REQ-035 SHALL be verified with terms 50,0,0,0 -> out_data=3, out_err=1.
REQ-036 SHALL be verified with out_ready=0 for 5 cycles in HOLD -> out_data/out_err constant, in_ready=0, in_valid pulses ignored; result delivered on first out_ready=1.
REQ-037 SHALL be verified with rst pulsed asynchronously after 2 of 4 terms (20,30) -> in_ready=1 and out_valid=0 immediately; new frame 5,5,5,5 yields 20.
REQ-038 SHALL be verified with N_TERMS=1 and back-to-back in_valid=1, out_ready=1, terms 7,47 -> outputs 7 then 0 with out_err=1, one accept every 2 cycles.
